elastic_pipe: RTL
=================

# elastic_pipe

Parametrised elastic pipeline of DEPTH valid/ready stages carrying WIDTH-bit payloads. It is the handshaked successor to the plain stall/bubble pipeline register: per-stage back-pressure, a global flush, and an optional skid buffer per stage for full throughput with registered ready. It sits between CPU pipeline sections, e.g. fetch→decode or memory-response paths, where downstream stalls must not be broadcast combinationally across the whole pipe.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 1, number of stages (≥1)
- BUBBLE_V, 0, WIDTH-bit value held in empty slots and driven on out_data when out_valid=0
- RESET_V, BUBBLE_V, WIDTH-bit value loaded into every slot data register on reset
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous: empties every stage
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  pipe accepts in_data this cycle
- in_data  in  WIDTH  payload
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  WIDTH  payload from last stage
- occupancy  out  $clog2(2*DEPTH+1)  number of valid entries held

## Operation
- Transfer on an edge where valid && ready (both sides). Data order preserved; no duplication or loss except by flush.
- Each stage holds a main slot; with PIPE_SKID_EN also a skid slot. Stage outputs come from main slot only.
- Stage accepts when main empty, or main draining this cycle (no-skid mode), or skid empty (skid mode).
- Skid mode: if a stage accepts while downstream is stalled and main is full, the word goes to skid; when main drains, skid moves to main in the same edge as any new acceptance goes to skid.
- flush has priority over all handshakes: at the edge, every valid bit clears and every data register loads BUBBLE_V. in_ready is forced 0 while flush=1 (no input accepted). An output handshake occurring in the flush cycle counts as delivered.
- Reset: all valids 0, data registers RESET_V, occupancy 0.
- occupancy = sum of valid slots; increments on in-transfer, decrements on out-transfer, unchanged when both; 0 after flush.
- out_data = BUBBLE_V whenever out_valid=0 (empty slot data always BUBBLE_V except immediately after reset, where RESET_V applies until first fill; out_data is still masked to BUBBLE_V when invalid).

## Timing
- Latency: an accepted word appears on out_valid DEPTH cycles later with no stalls.
- Throughput: 1 word/cycle sustained in both modes when out_ready=1.
- Skid mode: in_ready is a register output (per stage, ready = !skid_valid); no combinational path out_ready→in_ready. Capacity 2*DEPTH.
- No-skid mode: in_ready depends combinationally on out_ready through all DEPTH stages; capacity DEPTH.
- Reset values: in_ready=1 (deasserted only while resetn=0 is not required; during reset in_ready=0), out_valid=0, out_data=BUBBLE_V, occupancy=0.
- resetn assertion mid-transfer discards all contents immediately; first acceptance possible on first edge after release.
- Full: skid mode occupancy=2*DEPTH → in_ready=0 next cycle; simultaneous in/out at full in no-skid mode is accepted.

## Configuration
- PIPE_SKID_EN defined: skid slot per stage, registered in_ready, capacity 2*DEPTH, occupancy max 2*DEPTH.
- Undefined: main slot only, combinational ready chain, capacity DEPTH; occupancy width unchanged, max DEPTH.

## Structure
- Shared package pipe_pkg: occupancy width function (clog2 helper), stage-state enum {EMPTY, MAIN, MAIN_SKID} for the skid stage FSM.
- One sub-module elastic_pipe_slot (one stage, valid/ready both sides, flush, BUBBLE_V/RESET_V params); top instantiates DEPTH of them in a generate chain and counts occupancy.

## Test plan
- Reset: hold resetn=0 with in_valid=1 → out_valid=0, out_data=BUBBLE_V, occupancy=0; release, feed 0x11 → out 0x11 after DEPTH cycles.
- Streaming DEPTH=3, out_ready=1, inputs 1..10 back-to-back → outputs 1..10 in order, first at cycle 3, no gaps.
- Back-pressure: out_ready=0, push continuously → skid mode accepts 6 words (DEPTH=3) then in_ready=0, occupancy=6; no-skid accepts 3. Release → all delivered in order.
- Flush with pipe holding 4 words and in_valid=1 → in_ready=0 that cycle, next cycle out_valid=0, occupancy=0, out_data=BUBBLE_V; flushed input not delivered.
- Random valid/ready (10k cycles, both modes) → scoreboard order match, occupancy equals model, in_ready never depends on out_ready in skid mode (check via same-cycle toggling).
- Async reset asserted mid-stream at non-edge time → outputs reach reset values before next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the elastic pipeline
package pipe_pkg;

  // Occupancy of a single stage when the skid slot is present
  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    MAIN      = 2'd1,
    MAIN_SKID = 2'd2
  } slot_state_e;

  // Occupancy counter width: must hold 0..2*depth even when skid slots are absent
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_slot.sv
// rtl/elastic_pipe_slot.sv - one valid/ready stage; PIPE_SKID_EN adds a skid slot
module elastic_pipe_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] BUBBLE_V = '0,
  parameter logic [WIDTH-1:0] RESET_V  = BUBBLE_V
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             accept;
  logic             drain;

  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign out_valid = main_valid;
  // Mask so RESET_V never leaks out before the first fill
  assign out_data  = main_valid ? main_data : BUBBLE_V;

`ifdef PIPE_SKID_EN
  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] skid_data, main_d, skid_d;

  assign main_valid = (state_q != EMPTY);
  // Ready depends only on local state (and flush), never on out_ready
  assign in_ready   = !flush && (state_q != MAIN_SKID);

  // State and slot data registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= EMPTY;
      main_data <= RESET_V;
      skid_data <= RESET_V;
    end else begin
      state_q   <= state_d;
      main_data <= main_d;
      skid_data <= skid_d;
    end
  end

  // Next state: fill main first, overflow into skid, skid refills main on drain
  always_comb begin
    state_d = state_q;
    main_d  = main_data;
    skid_d  = skid_data;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_V;
      skid_d  = BUBBLE_V;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = MAIN;
            main_d  = in_data;
          end
        end
        MAIN: begin
          case ({accept, drain})
            2'b10: begin
              state_d = MAIN_SKID;
              skid_d  = in_data;
            end
            2'b11: main_d = in_data;
            2'b01: begin
              state_d = EMPTY;
              main_d  = BUBBLE_V;
            end
            default: ;
          endcase
        end
        MAIN_SKID: begin
          if (drain) begin
            state_d = MAIN;
            main_d  = skid_data;
            skid_d  = BUBBLE_V;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end
`else
  // Ready passes through when the word held here leaves this cycle
  assign in_ready = !flush && (!main_valid || out_ready);

  // Single main slot: load on accept, empty to bubble on drain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_valid <= 1'b0;
      main_data  <= RESET_V;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE_V;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (drain) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE_V;
    end
  end
`endif

endmodule

// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - DEPTH-stage elastic valid/ready pipe; PIPE_SKID_EN enables skid slots
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 1,
  parameter logic [WIDTH-1:0] BUBBLE_V = '0,
  parameter logic [WIDTH-1:0] RESET_V  = BUBBLE_V
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int               OCC_W   = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = 1;

  logic in_xfer;
  logic out_xfer;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             dn_ready;
    logic             rdy;
    logic             vld;
    logic [WIDTH-1:0] dat;

    if (g == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_mid
      assign up_valid = g_stage[g-1].vld;
      assign up_data  = g_stage[g-1].dat;
    end

    if (g == DEPTH - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_next
      assign dn_ready = g_stage[g+1].rdy;
    end

    elastic_pipe_slot #(
      .WIDTH   (WIDTH),
      .BUBBLE_V(BUBBLE_V),
      .RESET_V (RESET_V)
    ) u_slot (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush),
      .in_valid (up_valid),
      .in_ready (rdy),
      .in_data  (up_data),
      .out_valid(vld),
      .out_ready(dn_ready),
      .out_data (dat)
    );
  end

  // Hold off upstream while reset is asserted
  assign in_ready  = resetn && g_stage[0].rdy;
  assign out_valid = g_stage[DEPTH-1].vld;
  assign out_data  = g_stage[DEPTH-1].dat;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Entry count tracks handshakes at both ends; flush empties everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_ONE;
    end else if (!in_xfer && out_xfer) begin
      occupancy <= occupancy - OCC_ONE;
    end
  end

endmodule
